// File: rtl/piece_mover.sv
// Active-piece controller for a falling-block game: spawns a piece, applies gravity
// and player moves against the locked-cell board, and reports lock / game-over.
module piece_mover #(
  parameter int ROWS       = 22,
  parameter int COLS       = 12,
  parameter int GRAV_TICKS = 60,
  parameter int SPAWN_ROW  = 1,
  parameter int SPAWN_COL  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         start,
  input  logic [ROWS-1:0][COLS-1:0]    board,
  input  logic [3:0][3:0]              shape,
  input  logic [3:0][3:0]              shape_rot,
  input  logic                         move_left,
  input  logic                         move_right,
  input  logic                         rotate,
  input  logic                         soft_drop,
  output logic [$clog2(ROWS)-1:0]      row_out,
  output logic [$clog2(COLS)-1:0]      col_out,
  output logic                         rot_accept,
  output logic                         lock,
  output logic                         spawn,
  output logic                         game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW:0]   ROWS_W    = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_W    = (CW+1)'(COLS);
  localparam logic [RW-1:0] SROW      = RW'(SPAWN_ROW);
  localparam logic [CW-1:0] SCOL      = CW'(SPAWN_COL);
  localparam logic [7:0]    GRAV_LAST = 8'(GRAV_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_LOCK, S_OVER} state_t;

  state_t        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [7:0]    grav_q, grav_d;
  logic          rot_q, lock_q, spawn_q, over_q;

  logic [RW:0] row_x;
  logic [CW:0] col_x;
  logic coll_spawn, coll_down, coll_rot, coll_left, coll_right;
  logic grav_hit, act_down, go_spawn;

  // Sums are one bit wider than the board index so an out-of-range cell is caught, not wrapped.
  function automatic logic collide(input logic [3:0][3:0] m, input logic [RW:0] r,
                                   input logic [CW:0] c);
    logic        hit;
    logic [RW:0] ri;
    logic [CW:0] cj;
    hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        ri = r + (RW+1)'(i);
        cj = c + (CW+1)'(j);
        if (m[i][j]) begin
          if (ri >= ROWS_W || cj >= COLS_W) hit = 1'b1;
          else if (board[ri[RW-1:0]][cj[CW-1:0]]) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  always_comb begin
    row_x      = {1'b0, row_q};
    col_x      = {1'b0, col_q};
    coll_spawn = collide(shape, {1'b0, SROW}, {1'b0, SCOL});
    coll_down  = collide(shape, row_x + (RW+1)'(1), col_x);
    coll_rot   = collide(shape_rot, row_x, col_x);
    coll_left  = collide(shape, row_x, col_x - (CW+1)'(1));
    coll_right = collide(shape, row_x, col_x + (CW+1)'(1));
    grav_hit   = (grav_q == GRAV_LAST);
    grav_d     = grav_hit ? '0 : grav_q + 8'd1;
    act_down   = grav_hit || (!rotate && !move_left && !move_right && soft_drop);
    go_spawn   = ((state_q == S_IDLE || state_q == S_OVER) && start) || (state_q == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= SROW;
      col_q   <= SCOL;
      grav_q  <= '0;
      rot_q   <= 1'b0;
      lock_q  <= 1'b0;
      spawn_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      rot_q   <= 1'b0;
      lock_q  <= 1'b0;
      spawn_q <= 1'b0;
      case (state_q)
        S_SPAWN: begin
          state_q <= coll_spawn ? S_OVER : S_FALL;
          over_q  <= coll_spawn;
        end
        S_FALL: if (tick) begin
          grav_q <= grav_d;
          if (act_down) begin
            if (coll_down) begin
              state_q <= S_LOCK;
              lock_q  <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end else if (rotate) begin
            rot_q <= !coll_rot;
          end else if (move_left) begin
            if (col_q != '0 && !coll_left) col_q <= col_q - CW'(1);
          end else if (move_right) begin
            if (!coll_right) col_q <= col_q + CW'(1);
          end
        end
        default: ;
      endcase
      // Entry into SPAWN is shared by IDLE/GAME_OVER (on start) and LOCK (unconditional).
      if (go_spawn) begin
        state_q <= S_SPAWN;
        spawn_q <= 1'b1;
        over_q  <= 1'b0;
        row_q   <= SROW;
        col_q   <= SCOL;
        grav_q  <= '0;
      end
    end
  end

  assign row_out    = row_q;
  assign col_out    = col_q;
  assign rot_accept = rot_q;
  assign lock       = lock_q;
  assign spawn      = spawn_q;
  assign game_over  = over_q;

endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 Parameter ROWS, default 22, board rows; row 0 is top.
REQ-002 Parameter COLS, default 12, board columns; column 0 is left.
REQ-003 Parameter GRAV_TICKS, default 60, ticks between gravity steps; legal range 1..255.
REQ-004 Parameter SPAWN_ROW, default 1, spawn row; parameter SPAWN_COL, default 5, spawn column.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  one-cycle frame pulse; only cycles with tick=1 evaluate moves.
REQ-008 start  in  1  pulse; begins a game from IDLE or GAME_OVER.
REQ-009 board  in  ROWS x COLS  locked-cell occupancy map (1 = occupied); excludes the active piece.
REQ-010 shape  in  4 x 4  active piece mask; shape[r][c] is the cell at piece-relative row r, column c.
REQ-011 shape_rot  in  4 x 4  candidate mask for the next rotation.
REQ-012 move_left, move_right, rotate, soft_drop  in  1 each  level-sensitive requests, sampled on tick.
REQ-013 row_out  out  clog2(ROWS)  active piece top-left row; col_out  out  clog2(COLS)  active piece top-left column.
REQ-014 rot_accept  out  1  one-cycle pulse; the rotation was applied, upstream shall advance shape.
REQ-015 lock  out  1  one-cycle pulse; the piece has landed at row_out/col_out.
REQ-016 spawn  out  1  one-cycle pulse; a new piece has been placed at the spawn position.
REQ-017 game_over  out  1  sticky flag.

Function
REQ-018 States: IDLE, SPAWN, FALL, LOCK, GAME_OVER; all outputs are registered.
REQ-019 Collision(mask,r,c) is true when, for any set mask[i][j], any of the following holds: r+i >= ROWS, c+j >= COLS, or board[r+i][c+j]=1.
REQ-020 IDLE: start moves to SPAWN the next cycle; all other inputs are ignored.
REQ-021 SPAWN (1 cycle): load row=SPAWN_ROW and col=SPAWN_COL, clear the gravity counter, and pulse spawn.
REQ-022 SPAWN continued: if Collision(shape,SPAWN_ROW,SPAWN_COL) is true, go to GAME_OVER; otherwise go to FALL.
REQ-023 FALL: on each tick, increment the gravity counter; the counter wraps to 0 at GRAV_TICKS-1, and that tick is a "gravity tick".
REQ-024 At most one action per tick, in this priority order: gravity down > rotate > move_left > move_right > soft_drop down.
REQ-025 Down: if Collision(shape,row+1,col) is false, row increments; otherwise go to LOCK.
REQ-026 Rotate: if Collision(shape_rot,row,col) is false, pulse rot_accept; otherwise nothing changes.
REQ-027 Left: rejected when col=0; otherwise col decrements if Collision(shape,row,col-1) is false.
REQ-028 Right: col increments if Collision(shape,row,col+1) is false.
REQ-029 A rejected action leaves row/col unchanged and does not fall through to a lower-priority action.
REQ-030 A soft_drop that is blocked also goes to LOCK.
REQ-031 LOCK (1 cycle): pulse lock with row_out/col_out held at the landed position, then go to SPAWN.
REQ-032 GAME_OVER: game_over=1 and row/col are held; start clears game_over and goes to SPAWN.
REQ-033 A tick arriving while in SPAWN or LOCK is ignored and not queued.
REQ-034 Arithmetic: row+1, col+1 and r+i, c+j use width+1 bits, so out-of-range sums are detected rather than wrapped.
REQ-035 Inputs are sampled every clk cycle; no combinational path exists from inputs to outputs.

Reset
REQ-036 While rst_n=0: state=IDLE, row_out=SPAWN_ROW, col_out=SPAWN_COL, gravity counter=0, and rot_accept, lock, spawn, game_over are all 0.
REQ-037 A reset asserted mid-game aborts any pending action; no lock or spawn pulse is emitted.
REQ-038 After rst_n rises, the block leaves IDLE only on start.

Verification
REQ-039 Empty board, start, GRAV_TICKS=2, no requests: spawn pulse; row goes 1->2 on every 2nd tick until row 18 (4-row shape, rows 18-21); the next gravity tick gives a lock pulse followed by a spawn pulse.
REQ-040 Column-0-only mask at col=0 with move_left held: col stays 0; move_right moves col 0->1.
REQ-041 Right wall: 4-wide mask at col=8, COLS=12, move_right: rejected, col stays 8.
REQ-042 Rotate into occupied board cell: rot_accept=0 and position unchanged; rotate into free space: rot_accept pulses for exactly 1 cycle.
REQ-043 Gravity tick coinciding with move_left: row increments and col is unchanged.
REQ-044 board[1][5]=1 with shape[0][0]=1, then start: spawn pulse, then game_over=1; start again with a cleared board: game_over=0 and a new spawn pulse.
